// File: rtl/vga_timing_core.sv
// VGA raster timing generator: IDLE/RUN/DRAIN scan control, pixel/line counters,
// undelayed pixel coordinates and sync/blank outputs delayed to match the colour pipeline.
module vga_timing_core #(
  parameter int unsigned H_ACT    = 32'd640,
  parameter int unsigned H_FRONT  = 32'd16,
  parameter int unsigned H_SYNC   = 32'd96,
  parameter int unsigned H_BACK   = 32'd48,
  parameter int unsigned V_ACT    = 32'd480,
  parameter int unsigned V_FRONT  = 32'd10,
  parameter int unsigned V_SYNC   = 32'd2,
  parameter int unsigned V_BACK   = 32'd33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE_DLY = 32'd2,
  parameter int unsigned FRAME_W  = 32'd16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_VGA_HS,
  output logic               o_VGA_VS,
  output logic               o_VGA_blank,
  output logic [9:0]         o_x,
  output logic [9:0]         o_y,
  output logic               o_de,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_running
);

  localparam int unsigned H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned H_END   = H_START + H_ACT;
  localparam int unsigned V_END   = V_START + V_ACT;
  localparam int unsigned HW      = (H_TOTAL > 32'd1) ? $clog2(H_TOTAL) : 32'd1;
  localparam int unsigned VW      = (V_TOTAL > 32'd1) ? $clog2(V_TOTAL) : 32'd1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 32'd1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_r;
  state_e               next_state_s;
  logic                 cnt_en_s;
  logic                 frame_end_s;
  logic [HW-1:0]        h_cnt_r;
  logic [VW-1:0]        v_cnt_r;
  logic [31:0]          h_ext_s;
  logic [31:0]          v_ext_s;
  logic                 active_s;
  logic                 hs_on_s;
  logic                 vs_on_s;
  logic                 line_start_s;
  logic                 de_r;
  logic [9:0]           x_r;
  logic [9:0]           y_r;
  logic                 line_start_r;
  logic                 frame_start_r;
  logic [FRAME_W-1:0]   frame_cnt_r;
  logic                 running_r;
  logic [PIPE_DLY:0]    hs_pipe_r;
  logic [PIPE_DLY:0]    vs_pipe_r;
  logic [PIPE_DLY:0]    blank_pipe_r;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start beats stop in IDLE, a drain always finishes the frame
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  if (i_start) next_state_s = ST_RUN;   else next_state_s = ST_IDLE;
      ST_RUN:   if (i_stop)  next_state_s = ST_DRAIN; else next_state_s = ST_RUN;
      ST_DRAIN: if (frame_end_s) next_state_s = ST_IDLE; else next_state_s = ST_DRAIN;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cnt_en_s = 1'b0;
    case (state_r)
      ST_IDLE:  cnt_en_s = 1'b0;
      ST_RUN:   cnt_en_s = 1'b1;
      ST_DRAIN: cnt_en_s = 1'b1;
      default:  cnt_en_s = 1'b0;
    endcase
  end

  // Raster counters, held at the origin whenever the scan is not running
  always_ff @(posedge i_clk) begin
    if (i_rst || !cnt_en_s) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? '0 : v_cnt_r + VW'(1);
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
    end
  end

  // Region decode of the current counter state
  always_comb begin
    h_ext_s      = 32'(h_cnt_r);
    v_ext_s      = 32'(v_cnt_r);
    frame_end_s  = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    active_s     = cnt_en_s && (h_ext_s >= H_START) && (h_ext_s < H_END)
                   && (v_ext_s >= V_START) && (v_ext_s < V_END);
    hs_on_s      = cnt_en_s && (h_ext_s < H_SYNC);
    vs_on_s      = cnt_en_s && (v_ext_s < V_SYNC);
    line_start_s = active_s && (h_ext_s == H_START);
  end

  // Undelayed pixel-stage registers and scan status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_r          <= 1'b0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= '0;
      running_r     <= 1'b0;
    end else begin
      de_r          <= active_s;
      x_r           <= active_s ? 10'(h_ext_s - H_START) : 10'd0;
      y_r           <= active_s ? 10'(v_ext_s - V_START) : 10'd0;
      line_start_r  <= line_start_s;
      frame_start_r <= line_start_s && (v_ext_s == V_START);
      running_r     <= (next_state_s != ST_IDLE);
      if (cnt_en_s && frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      end
    end
  end

  // Sync/blank delay line; stage 0 lines up with o_de, reset flushes to idle levels
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_pipe_r    <= {(PIPE_DLY + 1){~HS_POL}};
      vs_pipe_r    <= {(PIPE_DLY + 1){~VS_POL}};
      blank_pipe_r <= '0;
    end else begin
      hs_pipe_r[0]    <= hs_on_s ? HS_POL : ~HS_POL;
      vs_pipe_r[0]    <= vs_on_s ? VS_POL : ~VS_POL;
      blank_pipe_r[0] <= active_s;
      for (int i = 1; i <= int'(PIPE_DLY); i++) begin
        hs_pipe_r[i]    <= hs_pipe_r[i-1];
        vs_pipe_r[i]    <= vs_pipe_r[i-1];
        blank_pipe_r[i] <= blank_pipe_r[i-1];
      end
    end
  end

  assign o_VGA_HS      = hs_pipe_r[PIPE_DLY];
  assign o_VGA_VS      = vs_pipe_r[PIPE_DLY];
  assign o_VGA_blank   = blank_pipe_r[PIPE_DLY];
  assign o_x           = x_r;
  assign o_y           = y_r;
  assign o_de          = de_r;
  assign o_line_start  = line_start_r;
  assign o_frame_start = frame_start_r;
  assign o_frame_cnt   = frame_cnt_r;
  assign o_running     = running_r;

endmodule
